// File: rtl/key_dir_scheduler.sv
// rtl/key_dir_scheduler.sv - keypress to one-move-per-tick snake direction scheduler
module key_dir_scheduler #(
    parameter int          DEPTH    = 4,
    parameter int          CW       = 3,
    parameter logic [7:0]  SC_UP    = 8'h1D,
    parameter logic [7:0]  SC_DOWN  = 8'h1B,
    parameter logic [7:0]  SC_LEFT  = 8'h1C,
    parameter logic [7:0]  SC_RIGHT = 8'h23
) (
    input  logic          CLK,
    input  logic          RESETn,
    input  logic          key_valid,
    input  logic [7:0]    key_code,
    input  logic          game_tick,
    input  logic          game_run,
    output logic [1:0]    dir,
    output logic          dir_valid,
    output logic [CW-1:0] q_count,
    output logic          overflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [CW-1:0] CNT_ONE = 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state;
    state_t        state_next;
    logic          key_q;
    logic [1:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic          press;
    logic          code_ok;
    logic [1:0]    code_dir;
    logic [1:0]    ref_dir;
    logic          legal;
    logic          full;
    logic          active;
    logic          flush;
    logic          push;
    logic          pop;
    logic          drop_full;

    // Decode the scancode and decide whether the press is a legal, pushable move
    always_comb begin
        code_ok  = 1'b1;
        code_dir = 2'b00;
        case (key_code)
            SC_UP:    code_dir = 2'b00;
            SC_DOWN:  code_dir = 2'b01;
            SC_LEFT:  code_dir = 2'b10;
            SC_RIGHT: code_dir = 2'b11;
            default:  code_ok  = 1'b0;
        endcase
        press     = key_valid & ~key_q;
        // Compare against the newest queued move so a burst cannot sneak in a reversal
        ref_dir   = (q_count != '0) ? mem[wr_ptr - PTR_ONE] : dir;
        legal     = code_ok && (code_dir != ref_dir) && (code_dir != (ref_dir ^ 2'b01));
        full      = (q_count == CNT_FULL);
        pop       = active && game_tick && (q_count != '0);
        push      = active && press && legal && (!full || pop);
        drop_full = active && press && legal && full && !pop;
    end

    // Next-state logic: IDLE keeps the FIFO flushed, leaving RUN flushes it too
    always_comb begin
        state_next = state;
        active     = 1'b0;
        flush      = 1'b0;
        case (state)
            IDLE: begin
                flush = 1'b1;
                if (game_run) state_next = RUN;
            end
            RUN: begin
                if (!game_run) begin
                    state_next = IDLE;
                    flush      = 1'b1;
                end else begin
                    active = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register and key level history for edge detection
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state <= IDLE;
            key_q <= 1'b0;
        end else begin
            state <= state_next;
            key_q <= key_valid;
        end
    end

    // FIFO storage; contents are only ever read below the occupancy count
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= code_dir;
    end

    // FIFO pointers, occupancy, current direction and sticky overflow
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            q_count   <= '0;
            dir       <= 2'b11;
            dir_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            dir_valid <= pop;
            if (pop) dir <= mem[rd_ptr];
            if (drop_full) overflow <= 1'b1;
            if (flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                q_count <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_ONE;
                if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
                case ({push, pop})
                    2'b10:   q_count <= q_count + CNT_ONE;
                    2'b01:   q_count <= q_count - CNT_ONE;
                    default: q_count <= q_count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_key_dir_scheduler.sv
// tb/tb_key_dir_scheduler.sv - randomized bench against a queue-based direction model
module tb_key_dir_scheduler;

    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk;
    logic          resetn;
    logic          key_valid;
    logic [7:0]    key_code;
    logic          game_tick;
    logic          game_run;
    logic [1:0]    dir;
    logic          dir_valid;
    logic [CW-1:0] q_count;
    logic          overflow;

    key_dir_scheduler #(.DEPTH(DEPTH), .CW(CW)) dut (
        .CLK       (clk),
        .RESETn    (resetn),
        .key_valid (key_valid),
        .key_code  (key_code),
        .game_tick (game_tick),
        .game_run  (game_run),
        .dir       (dir),
        .dir_valid (dir_valid),
        .q_count   (q_count),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [1:0] mq[$];
    logic [1:0] m_dir = 2'b11;
    logic       m_dv  = 1'b0;
    logic       m_ovf = 1'b0;
    logic       m_run = 1'b0;
    logic       m_kq  = 1'b0;

    logic [7:0] codes [4] = '{8'h1D, 8'h1B, 8'h1C, 8'h23};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int decode(input logic [7:0] c);
        case (c)
            8'h1D:   return 0;
            8'h1B:   return 1;
            8'h1C:   return 2;
            8'h23:   return 3;
            default: return -1;
        endcase
    endfunction

    task automatic model_step();
        int         k;
        logic [1:0] r;
        logic       popping;
        logic       do_push;
        if (!resetn) begin
            mq.delete();
            m_dir = 2'b11;
            m_dv  = 1'b0;
            m_ovf = 1'b0;
            m_run = 1'b0;
            m_kq  = 1'b0;
            return;
        end
        m_dv    = 1'b0;
        do_push = 1'b0;
        if (m_run && game_run) begin
            popping = game_tick && (mq.size() > 0);
            k = decode(key_code);
            if (key_valid && !m_kq && k >= 0) begin
                r = (mq.size() > 0) ? mq[$] : m_dir;
                if (k[1:0] != r && k[1:0] != (r ^ 2'b01)) begin
                    if (mq.size() < DEPTH || popping) do_push = 1'b1;
                    else m_ovf = 1'b1;
                end
            end
            if (popping) begin
                m_dir = mq.pop_front();
                m_dv  = 1'b1;
            end
            if (do_push) mq.push_back(k[1:0]);
        end else begin
            mq.delete();
        end
        m_run = game_run;
        m_kq  = key_valid;
    endtask

    task automatic cycle(input logic kv, input logic [7:0] kc, input logic tick,
                         input logic run, input logic rst_n);
        @(negedge clk);
        key_valid = kv;
        key_code  = kc;
        game_tick = tick;
        game_run  = run;
        resetn    = rst_n;
        model_step();
        @(posedge clk);
        #1;
        chk("dir", dir, m_dir);
        chk("dir_valid", dir_valid, m_dv);
        chk("q_count", q_count, mq.size());
        chk("overflow", overflow, m_ovf);
    endtask

    task automatic do_reset();
        repeat (2) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic press(input logic [7:0] c);
        cycle(1'b1, c, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, c, 1'b0, 1'b1, 1'b1);
    endtask

    logic [1:0] saved_dir;
    int         hold;
    logic       kv_r;
    logic [7:0] kc_r;
    logic       run_r;

    initial begin
        key_valid = 0; key_code = 0; game_tick = 0; game_run = 0; resetn = 0;

        // reset values
        repeat (2) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("rst_dir", dir, 2'b11);
        chk("rst_dv", dir_valid, 1'b0);
        chk("rst_qc", q_count, 0);
        chk("rst_ovf", overflow, 1'b0);

        // held W gives one push, then a tick moves it to dir
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 8'h1D, 1'b0, 1'b1, 1'b1);
        chk("w_edge_qc", q_count, 1);
        repeat (1000) cycle(1'b1, 8'h1D, 1'b0, 1'b1, 1'b1);
        chk("w_hold_qc", q_count, 1);
        cycle(1'b1, 8'h1D, 1'b1, 1'b1, 1'b1);
        chk("tick_dir", dir, 2'b00);
        chk("tick_dv", dir_valid, 1'b1);
        chk("tick_qc", q_count, 0);
        cycle(1'b0, 8'h1D, 1'b0, 1'b1, 1'b1);
        chk("tick_dv_once", dir_valid, 1'b0);

        // reversal and repeat of current direction are dropped
        do_reset();
        press(8'h1C);
        chk("rev_qc", q_count, 0);
        press(8'h23);
        chk("rep_qc", q_count, 0);
        press(8'h1D);
        chk("w_qc", q_count, 1);

        // fill, overflow on a legal fifth move, then drain in order
        press(8'h1C);
        press(8'h1B);
        press(8'h1C);
        chk("full_qc", q_count, 4);
        chk("full_ovf0", overflow, 1'b0);
        press(8'h1D);
        chk("ovf_qc", q_count, 4);
        chk("ovf_set", overflow, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b1); chk("seq0", dir, 2'b00);
        cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b1); chk("seq1", dir, 2'b10);
        cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b1); chk("seq2", dir, 2'b01);
        cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b1); chk("seq3", dir, 2'b10);
        chk("drain_qc", q_count, 0);
        chk("ovf_sticky", overflow, 1'b1);

        // full with simultaneous push and pop
        do_reset();
        press(8'h1D); press(8'h1C); press(8'h1B); press(8'h1C);
        cycle(1'b1, 8'h1D, 1'b1, 1'b1, 1'b1);
        chk("pp_qc", q_count, 4);
        chk("pp_dv", dir_valid, 1'b1);
        chk("pp_ovf", overflow, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

        // pause flushes, holds dir, ignores ticks
        cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        chk("pre_pause_qc", q_count, 2);
        saved_dir = dir;
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("pause_qc", q_count, 0);
        chk("pause_dir", dir, saved_dir);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        chk("pause_tick_dv", dir_valid, 1'b0);

        // reset mid-burst with a key held across it
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        press(8'h1C); press(8'h23);
        cycle(1'b1, 8'h1B, 1'b0, 1'b1, 1'b0);
        chk("mid_rst_dir", dir, 2'b11);
        chk("mid_rst_ovf", overflow, 1'b0);
        chk("mid_rst_qc", q_count, 0);
        repeat (3) cycle(1'b1, 8'h1B, 1'b0, 1'b1, 1'b1);
        chk("held_across_rst_qc", q_count, 0);

        // randomized traffic
        hold = 0; kv_r = 0; kc_r = 8'h00; run_r = 1;
        for (int i = 0; i < 4000; i++) begin
            if (hold == 0) begin
                kv_r = ~kv_r;
                if (kv_r) begin
                    kc_r = ($urandom_range(0, 9) < 8) ? codes[$urandom_range(0, 3)]
                                                      : 8'($urandom_range(0, 255));
                    hold = $urandom_range(1, 8);
                end else begin
                    hold = $urandom_range(1, 4);
                end
            end
            hold--;
            if ($urandom_range(0, 99) < 3) run_r = ~run_r;
            cycle(kv_r, kc_r, ($urandom_range(0, 3) == 0), run_r,
                  ($urandom_range(0, 299) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
